// File: rtl/i2s_rx_pkg.sv
// Shared audio definitions for the I2S capture and playback paths.
package i2s_rx_pkg;

  // Sample width shared with the DAC transmit path.
  localparam int AUDIO_WIDTH = 16;

  typedef logic [AUDIO_WIDTH-1:0] sample_t;

  // Channel encoding, matching the LRCK level on the wire.
  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync.sv
// N-stage synchronizer for an asynchronous pin plus a registered
// rising-edge strobe. The strobe output can be left unused when only the
// synchronized level is needed. STAGES must be at least 2.
module i2s_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_r;
  logic              q_d;

  // Shift the pin through the synchronizer chain and register the edge strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      q_d    <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      q_d    <= sync_r[STAGES-1];
      rise   <= sync_r[STAGES-1] & ~q_d;
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples BCK/LRCK/DIN in the clk domain, shifts in
// DATA_WIDTH bits per channel after the one-bit I2S delay slot, and presents
// each complete left/right pair with a one-cycle valid strobe.
import i2s_rx_pkg::*;

module i2s_rx #(
  parameter int DATA_WIDTH  = AUDIO_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bck,
  input  logic                  lrck,
  input  logic                  din,
  output logic [DATA_WIDTH-1:0] left,
  output logic [DATA_WIDTH-1:0] right,
  output logic                  valid,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic                  bck_rise;
  logic                  bck_level_unused;
  logic                  lrck_s;
  logic                  lrck_edge_unused;
  logic                  din_s;
  logic                  din_edge_unused;

  logic                  lrck_q;
  logic                  armed;
  logic                  chan;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [DATA_WIDTH-1:0] left_hold;
  logic                  left_ok;
  logic                  pair_pend;
  logic                  err_pend;
  logic                  lrck_change;
  logic                  word_open;

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_bck (
    .clk  (clk),
    .rst  (rst),
    .d    (bck),
    .q    (bck_level_unused),
    .rise (bck_rise)
  );

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk  (clk),
    .rst  (rst),
    .d    (lrck),
    .q    (lrck_s),
    .rise (lrck_edge_unused)
  );

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk  (clk),
    .rst  (rst),
    .d    (din),
    .q    (din_s),
    .rise (din_edge_unused)
  );

  // Decode helpers: an LRCK edge opens a new half-frame; a word is still
  // being collected while armed and short of DATA_WIDTH bits.
  always_comb begin
    lrck_change = (lrck_s != lrck_q);
    word_open   = armed && (cnt < CNT_FULL);
    shreg_next  = {shreg[DATA_WIDTH-2:0], din_s};
  end

  // Bit-level capture on each BCK rising strobe. Completion and error events
  // are staged in pair_pend/err_pend so outputs land one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      lrck_q    <= 1'b0;
      armed     <= 1'b0;
      chan      <= CHAN_LEFT;
      cnt       <= '0;
      shreg     <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      pair_pend <= 1'b0;
      err_pend  <= 1'b0;
    end else begin
      pair_pend <= 1'b0;
      err_pend  <= 1'b0;
      if (bck_rise) begin
        lrck_q <= lrck_s;
        if (lrck_change) begin
          // Delay slot of the new half-frame; a partial word is dropped.
          if (word_open) begin
            err_pend <= 1'b1;
            left_ok  <= 1'b0;
          end
          armed <= 1'b1;
          cnt   <= '0;
          chan  <= lrck_s;
        end else if (word_open) begin
          shreg <= shreg_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (chan == CHAN_LEFT) begin
              left_hold <= shreg_next;
              left_ok   <= 1'b1;
            end else if (left_ok) begin
              // A right word without a preceding left word is discarded.
              pair_pend <= 1'b1;
              left_ok   <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Output registers: words update together with the valid strobe and hold
  // otherwise; frame_err mirrors the staged error event.
  always_ff @(posedge clk) begin
    if (rst) begin
      left      <= '0;
      right     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= pair_pend;
      frame_err <= err_pend;
      if (pair_pend) begin
        left  <= left_hold;
        right <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: table-driven standard frames plus hand-written
// reset, short-frame and 12 MHz BCK sequences, checked against a scoreboard.
`timescale 1ns/1ps
import i2s_rx_pkg::*;

module tb_i2s_rx;

  logic    clk = 1'b0;
  logic    rst;
  logic    bck;
  logic    lrck;
  logic    din;
  sample_t left;
  sample_t right;
  logic    valid;
  logic    frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rlsb_cyc = 0;
  int vcyc     = 0;
  int valid_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] l_in;
    logic [31:0] r_in;
    sample_t     exp_l;
    sample_t     exp_r;
  } vec_t;

  vec_t vecs[5];

  i2s_rx dut (
    .clk       (clk),
    .rst       (rst),
    .bck       (bck),
    .lrck      (lrck),
    .din       (din),
    .left      (left),
    .right     (right),
    .valid     (valid),
    .frame_err (frame_err)
  );

  // Clock and cycle counter.
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: each valid pulse must match the oldest expected pair.
  always @(negedge clk) begin
    if (valid) begin
      vcyc = cyc;
      valid_cnt++;
      chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("pair", {left, right}, exp_q.pop_front());
    end
    if (frame_err) err_cnt++;
    if (valid && frame_err) both_cnt++;
  end

  // One I2S half-frame: bit 0 is the delay slot, bits 1..32 carry data[31:0]
  // MSB first. rst_bit >= 0 asserts rst for rst_len cycles in that bit.
  task automatic send_slot(input logic lr, input logic [31:0] data, input int nbits,
                           input int ph, input int rst_bit, input int rst_len);
    for (int i = 0; i < nbits; i++) begin
      bck  = 1'b0;
      lrck = lr;
      din  = (i >= 1 && i <= 32) ? data[32-i] : 1'b0;
      if (i == rst_bit) begin
        rst = 1'b1;
        repeat (rst_len) @(negedge clk);
        rst = 1'b0;
        chk("rst_left", 32'(left), 32'd0);
        chk("rst_right", 32'(right), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
      end
      repeat (ph) @(negedge clk);
      bck = 1'b1;
      if (lr && i == 16) rlsb_cyc = cyc;
      repeat (ph) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits, input int ph);
    send_slot(1'b0, l, nbits, ph, -1, 0);
    send_slot(1'b1, r, nbits, ph, -1, 0);
  endtask

  initial begin
    int err0;
    int val0;
    logic [15:0] rl;
    logic [15:0] rr;

    vecs[0] = '{32'h8001_0000, 32'h7FFE_0000, 16'h8001, 16'h7FFE};
    vecs[1] = '{32'h8001_0000, 32'h7FFE_0000, 16'h8001, 16'h7FFE};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_0000, 16'h0000, 16'hFFFF};
    vecs[3] = '{32'hCAFE_FFFF, 32'hCAFE_FFFF, 16'hCAFE, 16'hCAFE};
    vecs[4] = '{32'h5555_0000, 32'hAAAA_0000, 16'h5555, 16'hAAAA};

    rst = 1'b1; bck = 1'b0; lrck = 1'b0; din = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_left", 32'(left), 32'd0);
    chk("reset_right", 32'(right), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;

    // Leading right half-frame: arms the receiver, its word is discarded.
    send_slot(1'b1, 32'hFFFF_FFFF, 32, 8, -1, 0);

    // Standard 64-BCK frames at ~3 MHz, including a 32-bit slot.
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back({vecs[v].exp_l, vecs[v].exp_r});
      send_frame(vecs[v].l_in, vecs[v].r_in, 32, 8);
      if (v == 0) chk("latency", 32'(vcyc), 32'(rlsb_cyc + 5));
    end
    chk("std_valid_count", 32'(valid_cnt), 32'd5);

    // Reset for one cycle during left bit 8; that frame is lost.
    val0 = valid_cnt;
    err0 = err_cnt;
    send_slot(1'b0, 32'h1111_0000, 32, 8, 8, 1);
    send_slot(1'b1, 32'h2222_0000, 32, 8, -1, 0);
    chk("rst_mid_no_valid", 32'(valid_cnt), 32'(val0));
    exp_q.push_back({16'h4321, 16'h0F0F});
    send_frame(32'h4321_0000, 32'h0F0F_0000, 32, 8);
    chk("rst_mid_resume", 32'(valid_cnt), 32'(val0 + 1));

    // Reset released mid right half-frame.
    val0 = valid_cnt;
    send_slot(1'b0, 32'h5A5A_0000, 32, 8, -1, 0);
    send_slot(1'b1, 32'hA5A5_0000, 32, 8, 8, 3);
    chk("align_no_valid", 32'(valid_cnt), 32'(val0));
    exp_q.push_back({16'h1234, 16'hABCD});
    send_frame(32'h1234_0000, 32'hABCD_0000, 32, 8);
    chk("align_valid", 32'(valid_cnt), 32'(val0 + 1));
    chk("align_no_err", 32'(err_cnt), 32'(err0));

    // Short left half-frame: LRCK toggles after 10 data bits.
    val0 = valid_cnt;
    send_slot(1'b0, 32'h3C3C_0000, 11, 8, -1, 0);
    send_slot(1'b1, 32'h9999_0000, 32, 8, -1, 0);
    chk("short_err", 32'(err_cnt), 32'(err0 + 1));
    chk("short_no_valid", 32'(valid_cnt), 32'(val0));
    exp_q.push_back({16'h2468, 16'h1357});
    send_frame(32'h2468_0000, 32'h1357_0000, 32, 8);
    chk("short_recover", 32'(valid_cnt), 32'(val0 + 1));

    // BCK at clk/4 with minimal 17-bit slots and random samples.
    err0 = err_cnt;
    val0 = valid_cnt;
    for (int f = 0; f < 250; f++) begin
      rl = 16'($urandom_range(0, 65535));
      rr = 16'($urandom_range(0, 65535));
      exp_q.push_back({rl, rr});
      send_frame({rl, 16'h0}, {rr, 16'h0}, 17, 2);
    end
    repeat (10) @(negedge clk);
    chk("fast_valid_count", 32'(valid_cnt), 32'(val0 + 250));
    chk("fast_no_err", 32'(err_cnt), 32'(err0));
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("valid_err_exclusive", 32'(both_cnt), 32'd0);
    chk("total_err", 32'(err_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
